leb128_decoder: RTL and testbench
=================================

Name: leb128_decoder

Overview:
- Streaming LEB128 immediate decoder between the byte-wide code ROM port and the CPU decode stage.
- Consumes one code byte per accepted handshake and produces a 64-bit immediate for the CPU operand stack (i32.const/i64.const, br, local indices).
- Supports signed and unsigned forms at 32- and 64-bit width, and reports the encoded length.
- Flags over-long encodings as a trap code.

Parameters:
- OUT_W, 64, output value width; fixed at 64, i32 results carried in the low 32 bits.
- LEN_W, 4, width of the byte-count output; holds 1..10.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a decode; sampled only in IDLE
- is_signed  in  1  1 = SLEB128, 0 = ULEB128; latched on start
- is_32  in  1  1 = 32-bit immediate (max 5 bytes), 0 = 64-bit (max 10 bytes); latched on start
- in_data  in  8  code byte from ROM
- in_valid  in  1  in_data valid
- in_ready  out  1  decoder accepts in_data this cycle
- out_value  out  64  decoded immediate
- out_len  out  4  bytes consumed
- out_trap  out  2  0 none, 1 too long, 2 bad unused bits
- out_valid  out  1  result or trap available
- out_ready  in  1  consumer accepts result

Behaviour:
- Reset (reset=0, any time, asynchronous):
  - state goes to IDLE.
  - out_value=0, out_len=0, out_trap=0, out_valid=0, in_ready=0.
  - Accumulator and counters are cleared; any in-flight decode is dropped.
- States: IDLE, DECODE, DONE.
- IDLE:
  - in_ready=0.
  - On start=1, latch is_signed/is_32, clear the accumulator, set count=0, go to DECODE.
  - A byte present on in_data in the same cycle is not consumed.
- DECODE:
  - in_ready=1; a byte is accepted when in_valid&in_ready.
  - Per accepted byte: acc |= (byte[6:0] << 7*count), truncated to 64 bits; count++.
  - Final byte: byte[7]=0 →
    - Signed and 7*(count+1) < width: sign-extend from bit 7*count+6 up to width-1.
    - is_32: out_value[63:32]=0; signed i32 is sign-extended only to bit 31.
    - out_len = count+1, out_trap=0, go to DONE.
  - Over-long: byte[7]=1 on the max-th byte (5 for is_32, 10 otherwise) → out_trap=1, out_len=max, out_value=0, go to DONE.
  - start is ignored in DECODE.
- DONE:
  - out_valid=1, in_ready=0; outputs are stable until out_ready=1.
  - On out_ready=1, out_valid drops next cycle and state returns to IDLE.
  - start asserted in the same cycle as out_ready is ignored; a new start is needed from IDLE.
- Latency:
  - out_valid rises the cycle after the final byte is accepted.
  - Minimum per immediate: 1 start cycle + N byte cycles + 1 cycle.
- The last byte of a 10-byte i64 contributes only bit 0; handling of the remaining bits is set by the optional feature.

Optional Feature:
- Macro: LEB128_STRICT_EN.
- Defined: unused bits of the final max-length byte are checked.
  - Unsigned: bits must be 0.
  - Signed: bits must equal the value's sign bit.
  - i32 5th byte: checks bits[6:4].
  - i64 10th byte: checks bits[6:1].
  - Violation → out_trap=2, out_value=0, out_len=max, DONE.
- Undefined: unused bits are discarded silently, out_trap is never 2, and the value is truncated.

Test Plan:
- Unsigned i64 decode: start, is_signed=0, is_32=0, bytes E5 8E 26 → out_value=0x98765 (624485), out_len=3, out_trap=0, out_valid one cycle after the third byte.
- Signed i64 decode: is_signed=1, bytes C0 BB 78 → out_value=0xFFFFFFFFFFFE1DC0 (-123456), out_len=3; signed i32 with the same bytes → 0x00000000FFFE1DC0.
- Over-long i32: is_32=1, bytes 80 80 80 80 80 → out_trap=1, out_len=5, out_value=0; a 6th byte is not accepted (in_ready=0).
- Unused-bit check: is_32=1, unsigned, bytes FF FF FF FF 7F.
  - With LEB128_STRICT_EN → out_trap=2.
  - Without it → out_value=0xFFFFFFFF, out_trap=0, out_len=5.
- Backpressure: in_valid gaps between bytes of E5 8E 26 give an unchanged result. out_ready held low for 5 cycles keeps out_valid=1 and out_value stable. Start pulses during DECODE/DONE are ignored.
- Reset mid-decode: assert reset=0 after 2 of 3 bytes → outputs 0 immediately, state IDLE. After release, a new start with byte 2A returns 42, out_len=1.

Source files
------------

// File: rtl/leb128_decoder.sv
// -----------------------------------------------------------------------------
// leb128_decoder
//
// Streaming LEB128 immediate decoder. It sits between the byte-wide code ROM
// port and the CPU decode stage. Each accepted byte adds seven payload bits to
// an accumulator. The final byte (bit 7 clear) produces a 64-bit immediate for
// the operand stack. Signed (SLEB128) and unsigned (ULEB128) forms are handled
// at both 32-bit and 64-bit width.
//
// Optional build macro: LEB128_STRICT_EN
//   When defined, the unused high bits of a maximum-length final byte are
//   checked. For unsigned values they must be zero. For signed values they must
//   equal the sign bit. A violation returns trap code 2.
//   When undefined, those bits are dropped silently and trap code 2 never
//   occurs.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   begin a decode (looked at only while idle)
//   is_signed  in   1 = SLEB128, 0 = ULEB128 (latched on start)
//   is_32      in   1 = 32-bit immediate, max 5 bytes (latched on start)
//   in_data    in   code byte from ROM
//   in_valid   in   in_data valid
//   in_ready   out  decoder accepts in_data this cycle
//   out_value  out  decoded immediate (i32 results in the low 32 bits)
//   out_len    out  number of bytes consumed
//   out_trap   out  0 none, 1 too long, 2 bad unused bits
//   out_valid  out  result or trap available
//   out_ready  in   consumer accepts the result
// -----------------------------------------------------------------------------
module leb128_decoder #(
    parameter int OUT_W = 64,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic             is_32,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_value,
    output logic [LEN_W-1:0] out_len,
    output logic [1:0]       out_trap,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] TRAP_NONE   = 2'd0;
    localparam logic [1:0] TRAP_LONG   = 2'd1;
`ifdef LEB128_STRICT_EN
    localparam logic [1:0] TRAP_UNUSED = 2'd2;
`endif

    state_t            state_q, state_d;
    logic              signed_q, signed_d;
    logic              is32_q, is32_d;
    logic [OUT_W-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [OUT_W-1:0]  value_q, value_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [1:0]        trap_q, trap_d;

    // Per-byte datapath signals.
    logic [LEN_W-1:0]  max_cnt;
    logic              last_byte;
    logic [6:0]        shift_amt;
    logic [6:0]        nbits;
    logic [OUT_W-1:0]  contrib;
    logic [OUT_W-1:0]  acc_next;
    logic              accept;
    logic              fin_ok;
    logic              fin_trap;

    // Shape the accumulated payload into the final immediate.
    //   nbits : payload bits collected so far (7 * bytes)
    //   sgn   : SLEB128 form
    //   w32   : 32-bit immediate
    // A signed value shorter than its width is sign-extended from bit nbits-1.
    // The extension uses an arithmetic shift pair. An i32 result then has its
    // upper half cleared, so the extension stops at bit 31.
    function automatic logic [OUT_W-1:0] shape_value(
        input logic [OUT_W-1:0] acc,
        input logic [6:0]       nb,
        input logic             sgn,
        input logic             w32
    );
        logic signed [OUT_W-1:0] tmp;
        logic [6:0]              width;
        logic [6:0]              sh;
        width = w32 ? 7'd32 : 7'd64;
        tmp   = acc;
        if (sgn && (nb < width)) begin
            sh  = 7'd64 - nb;
            tmp = (tmp <<< sh) >>> sh;
        end
        if (w32) begin
            tmp[OUT_W-1:32] = '0;
        end
        return tmp;
    endfunction

`ifdef LEB128_STRICT_EN
    // Check the unused bits of a maximum-length final byte.
    // For i32, bits [3:0] of the 5th byte land on value bits 31..28, so bit 3
    // is the sign. For i64, only bit 0 of the 10th byte is payload (value bit
    // 63).
    function automatic logic unused_bits_bad(
        input logic [7:0] b,
        input logic       sgn,
        input logic       w32
    );
        logic [5:0] bits;
        logic [5:0] want;
        if (w32) begin
            bits = {3'b000, b[6:4]};
            want = {3'b000, {3{sgn & b[3]}}};
        end else begin
            bits = b[6:1];
            want = {6{sgn & b[0]}};
        end
        return bits != want;
    endfunction
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            signed_q <= 1'b0;
            is32_q   <= 1'b0;
            acc_q    <= '0;
            count_q  <= '0;
            value_q  <= '0;
            len_q    <= '0;
            trap_q   <= TRAP_NONE;
        end else begin
            state_q  <= state_d;
            signed_q <= signed_d;
            is32_q   <= is32_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            value_q  <= value_d;
            len_q    <= len_d;
            trap_q   <= trap_d;
        end
    end

    // Per-byte decode: where this byte's payload lands, and whether the byte
    // ends the decode.
    always_comb begin
        max_cnt   = is32_q ? LEN_W'(5) : LEN_W'(10);
        last_byte = (count_q == (max_cnt - LEN_W'(1)));
        shift_amt = 7'(count_q) * 7'd7;
        nbits     = shift_amt + 7'd7;
        // Shifting left by up to 63 drops payload bits above bit 63. This is
        // how the 10th byte of an i64 contributes only its bit 0.
        contrib   = {{(OUT_W-7){1'b0}}, in_data[6:0]} << shift_amt;
        acc_next  = acc_q | contrib;
        accept    = (state_q == S_DECODE) && in_valid;
        fin_ok    = accept && !in_data[7];
        fin_trap  = accept && in_data[7] && last_byte;
    end

    // Register updates.
    always_comb begin
        signed_d = signed_q;
        is32_d   = is32_q;
        acc_d    = acc_q;
        count_d  = count_q;
        value_d  = value_q;
        len_d    = len_q;
        trap_d   = trap_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    signed_d = is_signed;
                    is32_d   = is_32;
                    acc_d    = '0;
                    count_d  = '0;
                end
            end
            S_DECODE: begin
                if (fin_trap) begin
                    value_d = '0;
                    len_d   = max_cnt;
                    trap_d  = TRAP_LONG;
                end else if (fin_ok) begin
                    value_d = shape_value(acc_next, nbits, signed_q, is32_q);
                    len_d   = count_q + LEN_W'(1);
                    trap_d  = TRAP_NONE;
`ifdef LEB128_STRICT_EN
                    if (last_byte && unused_bits_bad(in_data, signed_q, is32_q)) begin
                        value_d = '0;
                        len_d   = max_cnt;
                        trap_d  = TRAP_UNUSED;
                    end
`endif
                end else if (accept) begin
                    acc_d   = acc_next;
                    count_d = count_q + LEN_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_DECODE;
            S_DECODE: if (fin_ok || fin_trap) state_d = S_DONE;
            S_DONE:   if (out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs. The result registers stay stable throughout DONE.
    always_comb begin
        in_ready  = (state_q == S_DECODE);
        out_valid = (state_q == S_DONE);
        out_value = value_q;
        out_len   = len_q;
        out_trap  = trap_q;
    end

endmodule

// File: tb/tb_leb128_decoder.sv
module tb_leb128_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic        is_32 = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] out_value;
    logic [3:0]  out_len;
    logic [1:0]  out_trap;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        sgn;
        logic        w32;
        int          n;
        logic [79:0] bytes;   // byte i at [8*i +: 8]
        logic [63:0] val;
        logic [3:0]  len;
        logic [1:0]  trap;
    } vec_t;

    typedef struct {
        logic [63:0] val;
        logic [3:0]  len;
        logic [1:0]  trap;
    } exp_t;

    exp_t exp_q[$];

    leb128_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .is_32     (is_32),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_value (out_value),
        .out_len   (out_len),
        .out_trap  (out_trap),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic sgn, input logic w32, input int n,
                                input logic [79:0] bytes, input logic [63:0] val,
                                input logic [3:0] len, input logic [1:0] trap);
        vec_t v;
        v.sgn = sgn; v.w32 = w32; v.n = n; v.bytes = bytes;
        v.val = val; v.len = len; v.trap = trap;
        return v;
    endfunction

    // Start cycle. A byte is presented but must not be consumed.
    task automatic start_dec(input logic sgn, input logic w32, input logic [7:0] b0);
        is_signed = sgn;
        is_32     = w32;
        start     = 1'b1;
        in_valid  = 1'b1;
        in_data   = b0;
        @(posedge clk); #1;
        start     = 1'b0;
        in_valid  = 1'b0;
    endtask

    // Present one byte after 'gap' idle cycles, with start pulsed during the gap.
    task automatic send_byte(input logic [7:0] b, input int gap, input string tag);
        int k;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            start    = 1'b1;
            @(posedge clk); #1;
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) chk({tag, "_in_ready_timeout"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic finish_vec(input int hold, input string tag);
        int   k;
        exp_t e;
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_latency"}, 64'(k), 64'd0);
        if (out_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_value"}, out_value, e.val);
            chk({tag, "_len"}, 64'(out_len), 64'(e.len));
            chk({tag, "_trap"}, 64'(out_trap), 64'(e.trap));
            chk({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
            for (int h = 0; h < hold; h++) begin
                start    = 1'b1;
                in_valid = 1'b1;
                @(posedge clk); #1;
                chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
                chk({tag, "_hold_value"}, out_value, e.val);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            start     = (hold > 0);
            @(posedge clk); #1;
            out_ready = 1'b0;
            start     = 1'b0;
            chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
            if (hold > 0) begin
                @(posedge clk); #1;
                chk({tag, "_start_ignored"}, 64'(in_ready), 64'd0);
            end
        end else begin
            chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        end
    endtask

    task automatic run_vec(input vec_t v, input int gap, input int hold, input string tag);
        exp_t e;
        e.val = v.val; e.len = v.len; e.trap = v.trap;
        exp_q.push_back(e);
        start_dec(v.sgn, v.w32, v.bytes[7:0]);
        for (int i = 0; i < v.n; i++) begin
            send_byte(v.bytes[8*i +: 8], gap, tag);
        end
        finish_vec(hold, tag);
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = mk(0, 0, 3, 80'h26_8E_E5, 64'h0000000000098765, 4'd3, 2'd0);
        vecs[1]  = mk(1, 0, 3, 80'h78_BB_C0, 64'hFFFFFFFFFFFE1DC0, 4'd3, 2'd0);
        vecs[2]  = mk(1, 1, 3, 80'h78_BB_C0, 64'h00000000FFFE1DC0, 4'd3, 2'd0);
        vecs[3]  = mk(0, 1, 5, 80'h80_80_80_80_80, 64'h0, 4'd5, 2'd1);
`ifdef LEB128_STRICT_EN
        vecs[4]  = mk(0, 1, 5, 80'h7F_FF_FF_FF_FF, 64'h0, 4'd5, 2'd2);
        vecs[7]  = mk(0, 0, 10, 80'h7F_FF_FF_FF_FF_FF_FF_FF_FF_FF, 64'h0, 4'd10, 2'd2);
`else
        vecs[4]  = mk(0, 1, 5, 80'h7F_FF_FF_FF_FF, 64'h00000000FFFFFFFF, 4'd5, 2'd0);
        vecs[7]  = mk(0, 0, 10, 80'h7F_FF_FF_FF_FF_FF_FF_FF_FF_FF, 64'hFFFFFFFFFFFFFFFF, 4'd10, 2'd0);
`endif
        vecs[5]  = mk(1, 0, 1, 80'h7F, 64'hFFFFFFFFFFFFFFFF, 4'd1, 2'd0);
        vecs[6]  = mk(0, 0, 10, 80'h01_FF_FF_FF_FF_FF_FF_FF_FF_FF, 64'hFFFFFFFFFFFFFFFF, 4'd10, 2'd0);
        vecs[8]  = mk(0, 0, 10, 80'h80_80_80_80_80_80_80_80_80_80, 64'h0, 4'd10, 2'd1);
        vecs[9]  = mk(1, 1, 5, 80'h78_80_80_80_80, 64'h0000000080000000, 4'd5, 2'd0);
        vecs[10] = mk(0, 1, 1, 80'h00, 64'h0, 4'd1, 2'd0);
        vecs[11] = mk(1, 0, 2, 80'h7F_80, 64'hFFFFFFFFFFFFFF80, 4'd2, 2'd0);
        vecs[12] = mk(1, 1, 1, 80'h40, 64'h00000000FFFFFFC0, 4'd1, 2'd0);
        vecs[13] = mk(1, 0, 10, 80'h7F_FF_FF_FF_FF_FF_FF_FF_FF_FF, 64'hFFFFFFFFFFFFFFFF, 4'd10, 2'd0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_value", out_value, 64'd0);
        chk("rst_out_len", 64'(out_len), 64'd0);
        chk("rst_out_trap", 64'(out_trap), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], 0, 0, $sformatf("vec%0d", i));
        end

        // Input gaps with start pulses during DECODE, then output backpressure
        // with start pulses during DONE.
        run_vec(vecs[0], 2, 5, "backpressure");

        // Reset in the middle of a decode (the previous result is still held).
        start_dec(1'b0, 1'b0, 8'hE5);
        send_byte(8'hE5, 0, "midrst");
        send_byte(8'h8E, 0, "midrst");
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_out_value", out_value, 64'd0);
        chk("midrst_out_len", 64'(out_len), 64'd0);
        chk("midrst_out_trap", 64'(out_trap), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_idle", 64'(in_ready), 64'd0);
        run_vec(mk(0, 0, 1, 80'h2A, 64'd42, 4'd1, 2'd0), 0, 0, "after_rst");

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
